// File: rtl/mips_core_pkg.sv
// Shared types for the multithreaded MIPS core: thread ids and scheduler states.
package mips_core_pkg;

    localparam int unsigned ADDR_WIDTH = 32;

    typedef logic ThreadId;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ALL_DONE = 2'd2
    } SchedState;

endpackage

// File: rtl/thread_quantum_timer.sv
// Run-length counter for the active thread; flags expiry on the last cycle of a quantum.
module thread_quantum_timer #(
    parameter int unsigned QUANTUM = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int unsigned CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [CW-1:0] LAST = CW'(QUANTUM - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so a missed clear can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expire = en && (count == LAST);

endmodule

// File: rtl/thread_scheduler.sv
// Two-thread coarse-grained scheduler: yields on miss/done (and quantum expiry when
// THREAD_QUANTUM_EN is defined), saves resume PCs and redirects fetch.
module thread_scheduler
    import mips_core_pkg::*;
#(
`ifdef THREAD_QUANTUM_EN
    parameter int unsigned QUANTUM = 256,
`endif
    parameter logic [ADDR_WIDTH-1:0] RESET_PC0    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC1    = 32'h0000_1000,
    parameter int unsigned           DRAIN_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        miss_event,
    input  logic                        done_event,
    input  logic [ADDR_WIDTH-1:0]       switch_pc,
    output ThreadId                     thread_id,
    output logic                        thread_switch,
    output logic                        current_thread_done,
    output logic                        thread_0_done,
    output logic                        thread_1_done,
    output logic [1:0][ADDR_WIDTH-1:0]  thread_resume_pc,
    output logic                        load_pc_we,
    output logic [ADDR_WIDTH-1:0]       load_pc_new_pc
);

    SchedState  state;
    logic [3:0] drain_cnt;
    logic [1:0] done;
    logic       quantum_expire;
    logic       trigger;
    ThreadId    other;

    assign other   = ~thread_id;
    assign trigger = done_event | miss_event | quantum_expire;

`ifdef THREAD_QUANTUM_EN
    thread_quantum_timer #(
        .QUANTUM (QUANTUM)
    ) u_quantum (
        .clk    (clk),
        .rst    (rst),
        .en     (state == RUN),
        .clr    ((state == RUN) && trigger),
        .expire (quantum_expire)
    );
`else
    assign quantum_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            drain_cnt        <= '0;
            done             <= '0;
            thread_id        <= 1'b0;
            thread_switch    <= 1'b0;
            load_pc_we       <= 1'b0;
            load_pc_new_pc   <= RESET_PC0;
            thread_resume_pc <= {RESET_PC1, RESET_PC0};
        end else begin
            thread_switch <= 1'b0;
            load_pc_we    <= 1'b0;
            unique case (state)
                RUN: begin
                    if (trigger) begin
                        if (!done[other]) begin
                            thread_resume_pc[thread_id] <= switch_pc;
                            thread_id                   <= other;
                            load_pc_new_pc              <= thread_resume_pc[other];
                            load_pc_we                  <= 1'b1;
                            thread_switch               <= 1'b1;
                            if (done_event) begin
                                done[thread_id] <= 1'b1;
                            end
                            drain_cnt <= 4'(DRAIN_CYCLES - 1);
                            state     <= DRAIN;
                        end else if (done_event) begin
                            // Nothing left to switch to: retire the last thread.
                            done[thread_id] <= 1'b1;
                            state           <= ALL_DONE;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                ALL_DONE: begin
                end
                default: state <= RUN;
            endcase
        end
    end

    assign thread_0_done       = done[0];
    assign thread_1_done       = done[1];
    assign current_thread_done = done[thread_id];

endmodule

// File: tb/tb_thread_scheduler.sv
// Table-driven scoreboard bench for thread_scheduler; quantum sequence runs when
// THREAD_QUANTUM_EN is defined.
module tb_thread_scheduler;
    import mips_core_pkg::*;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    typedef struct packed {
        logic        tid;
        logic        sw;
        logic        we;
        logic        cd;
        logic        d0;
        logic        d1;
        logic [31:0] npc;
        logic [31:0] rpc0;
        logic [31:0] rpc1;
    } outs_t;

    typedef struct packed {
        logic        rst;
        logic        miss;
        logic        done;
        logic [31:0] pc;
        outs_t       exp;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  miss_event = 1'b0;
    logic                  done_event = 1'b0;
    logic [31:0]           switch_pc = '0;
    ThreadId               thread_id;
    logic                  thread_switch;
    logic                  current_thread_done;
    logic                  thread_0_done;
    logic                  thread_1_done;
    logic [1:0][31:0]      thread_resume_pc;
    logic                  load_pc_we;
    logic [31:0]           load_pc_new_pc;

    int    n_vec  = 0;
    int    n_miss = 0;
    vec_t  vecs[$];
    outs_t exp_q[$];

    always #5 clk = ~clk;

    thread_scheduler #(
`ifdef THREAD_QUANTUM_EN
        .QUANTUM      (8),
`endif
        .RESET_PC0    (32'h0000_0000),
        .RESET_PC1    (32'h0000_1000),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .miss_event          (miss_event),
        .done_event          (done_event),
        .switch_pc           (switch_pc),
        .thread_id           (thread_id),
        .thread_switch       (thread_switch),
        .current_thread_done (current_thread_done),
        .thread_0_done       (thread_0_done),
        .thread_1_done       (thread_1_done),
        .thread_resume_pc    (thread_resume_pc),
        .load_pc_we          (load_pc_we),
        .load_pc_new_pc      (load_pc_new_pc)
    );

    // Upstream contract: no done_event while the pipeline drains.
    always @(posedge clk) begin
        if (!rst && done_event && dut.state == DRAIN) begin
            $display("FAIL drain_done_assert: done_event seen in DRAIN at %0t", $time);
            n_miss++;
        end
    end

    function automatic outs_t eo(input logic tid, input logic sw, input logic [31:0] npc,
                                 input logic [31:0] r0, input logic [31:0] r1,
                                 input logic d0, input logic d1);
        outs_t o;
        o.tid  = tid;
        o.sw   = sw;
        o.we   = sw;
        o.cd   = tid ? d1 : d0;
        o.d0   = d0;
        o.d1   = d1;
        o.npc  = npc;
        o.rpc0 = r0;
        o.rpc1 = r1;
        return o;
    endfunction

    task automatic add(input logic r, input logic m, input logic d, input logic [31:0] pc,
                       input outs_t e);
        vec_t v;
        v.rst  = r;
        v.miss = m;
        v.done = d;
        v.pc   = pc;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic step(input vec_t v, input string name);
        outs_t got;
        outs_t e;
        @(negedge clk);
        rst        = v.rst;
        miss_event = v.miss;
        done_event = v.done;
        switch_pc  = v.pc;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        got.tid  = thread_id;
        got.sw   = thread_switch;
        got.we   = load_pc_we;
        got.cd   = current_thread_done;
        got.d0   = thread_0_done;
        got.d1   = thread_1_done;
        got.npc  = load_pc_new_pc;
        got.rpc0 = thread_resume_pc[0];
        got.rpc1 = thread_resume_pc[1];
        e = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_miss++;
            $display("FAIL %s: got tid=%0b sw=%0b we=%0b cd=%0b d=%0b%0b npc=%h rpc0=%h rpc1=%h ; want tid=%0b sw=%0b we=%0b cd=%0b d=%0b%0b npc=%h rpc0=%h rpc1=%h",
                     name, got.tid, got.sw, got.we, got.cd, got.d1, got.d0, got.npc,
                     got.rpc0, got.rpc1, e.tid, e.sw, e.we, e.cd, e.d1, e.d0, e.npc,
                     e.rpc0, e.rpc1);
        end
    endtask

    initial begin
        outs_t rs;
        rs = eo(F, F, 32'h0, 32'h0, 32'h1000, F, F);
`ifndef THREAD_QUANTUM_EN
        repeat (2)  add(T, F, F, 32'h0, rs);
        repeat (10) add(F, F, F, 32'h0, rs);
        add(F, T, F, 32'h40, eo(T, T, 32'h1000, 32'h40, 32'h1000, F, F));
        repeat (3)  add(F, T, F, 32'h99, eo(T, F, 32'h1000, 32'h40, 32'h1000, F, F));
        add(F, T, F, 32'h2000, eo(F, T, 32'h40, 32'h40, 32'h2000, F, F));
        repeat (3)  add(F, F, F, 32'h0, eo(F, F, 32'h40, 32'h40, 32'h2000, F, F));
        add(F, T, T, 32'h44, eo(T, T, 32'h2000, 32'h44, 32'h2000, T, F));
        repeat (3)  add(F, F, F, 32'h0, eo(T, F, 32'h2000, 32'h44, 32'h2000, T, F));
        add(F, T, F, 32'h3000, eo(T, F, 32'h2000, 32'h44, 32'h2000, T, F));
        add(F, F, F, 32'h0,    eo(T, F, 32'h2000, 32'h44, 32'h2000, T, F));
        add(F, F, T, 32'h2020, eo(T, F, 32'h2000, 32'h44, 32'h2000, T, T));
        add(F, T, F, 32'h4000, eo(T, F, 32'h2000, 32'h44, 32'h2000, T, T));
        add(F, F, T, 32'h5000, eo(T, F, 32'h2000, 32'h44, 32'h2000, T, T));
        add(F, F, F, 32'h0,    eo(T, F, 32'h2000, 32'h44, 32'h2000, T, T));
        add(T, F, F, 32'h0, rs);
        add(F, T, F, 32'h80, eo(T, T, 32'h1000, 32'h80, 32'h1000, F, F));
        add(T, F, F, 32'h0, rs);
        add(F, T, F, 32'h84, eo(T, T, 32'h1000, 32'h84, 32'h1000, F, F));
        repeat (3)  add(F, F, F, 32'h0, eo(T, F, 32'h1000, 32'h84, 32'h1000, F, F));
        add(F, F, T, 32'h1100, eo(F, T, 32'h84, 32'h84, 32'h1100, F, T));
        add(F, F, F, 32'h0,    eo(F, F, 32'h84, 32'h84, 32'h1100, F, T));
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end
`else
        begin
            vec_t        v;
            logic        tid;
            logic [31:0] npc;
            logic [31:0] r0;
            logic [31:0] r1;
            logic        sw;
            v = '0;
            v.rst = T;
            v.exp = rs;
            repeat (2) step(v, "q_reset");
            tid = F; npc = 32'h0; r0 = 32'h0; r1 = 32'h1000;
            v.rst = F;
            v.pc  = 32'h500;
            // First switch 8 cycles after reset, then every QUANTUM + DRAIN_CYCLES.
            for (int i = 0; i < 30; i++) begin
                sw = (i == 7) || (i == 18) || (i == 29);
                if (sw) begin
                    if (tid) r1 = 32'h500; else r0 = 32'h500;
                    tid = ~tid;
                    npc = tid ? r1 : r0;
                end
                v.exp = eo(tid, sw, npc, r0, r1, F, F);
                step(v, $sformatf("q_run%0d", i));
            end
            v.rst = T;
            v.exp = rs;
            step(v, "q_rst_mid_drain");
            v.rst  = F;
            v.done = T;
            v.pc   = 32'h600;
            v.exp  = eo(T, T, 32'h1000, 32'h600, 32'h1000, T, F);
            step(v, "q_done_t0");
            v.done = F;
            v.pc   = 32'h700;
            v.exp  = eo(T, F, 32'h1000, 32'h600, 32'h1000, T, F);
            for (int i = 0; i < 40; i++) begin
                step(v, $sformatf("q_noswitch%0d", i));
            end
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
